// File: rtl/mmb_burst_splitter.sv
// Splits master bursts into sub-bursts of at most 2^MBWIDTH words for a short-burst slave.
// Optional MMB_BURST_SPLITTER_BOUNDARY_EN: sub-bursts never cross an aligned 2^MBWIDTH-word boundary.
module mmb_burst_splitter #(
    parameter int unsigned AWIDTH  = 8,
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned BWIDTH  = 4,
    parameter int unsigned MBWIDTH = 2
) (
    input  logic               reset,
    input  logic               clk,
    input  logic [AWIDTH-1:0]  s_addr,
    input  logic [BWIDTH-1:0]  s_bcnt,
    input  logic               s_wreq,
    input  logic [DWIDTH-1:0]  s_wdat,
    input  logic               s_rreq,
    output logic [DWIDTH-1:0]  s_rdat,
    output logic               s_rval,
    output logic               s_busy,
    output logic [AWIDTH-1:0]  m_addr,
    output logic [MBWIDTH-1:0] m_bcnt,
    output logic               m_wreq,
    output logic [DWIDTH-1:0]  m_wdat,
    output logic               m_rreq,
    input  logic [DWIDTH-1:0]  m_rdat,
    input  logic               m_rval,
    input  logic               m_busy
);

    localparam int unsigned RW  = BWIDTH + 1;
    localparam int unsigned SUB = 1 << MBWIDTH;
`ifdef MMB_BURST_SPLITTER_BOUNDARY_EN
    localparam bit BOUNDARY_EN = 1'b1;
`else
    localparam bit BOUNDARY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t            state, state_n;
    logic [AWIDTH-1:0] cur_addr, cur_addr_n;
    logic [RW-1:0]     rem, rem_n;
    logic [RW-1:0]     sub_rem, sub_rem_n;
    logic [MBWIDTH-1:0] bcnt_hold, bcnt_hold_n;
    logic [RW-1:0]     len_v;
    logic [RW-1:0]     n_s;

    // Sub-burst length for a given address offset and remaining word count
    function automatic logic [RW-1:0] sub_len(input logic [MBWIDTH-1:0] off,
                                              input logic [RW-1:0] r);
        logic [RW-1:0] room;
        room = RW'(SUB) - (BOUNDARY_EN ? RW'(off) : RW'(0));
        return (r < room) ? r : room;
    endfunction

    assign n_s    = RW'(s_bcnt) + RW'(1);
    assign s_rdat = m_rdat;
    assign s_rval = m_rval;
    assign m_wdat = s_wdat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            rem       <= '0;
            sub_rem   <= '0;
            bcnt_hold <= '0;
        end else begin
            state     <= state_n;
            cur_addr  <= cur_addr_n;
            rem       <= rem_n;
            sub_rem   <= sub_rem_n;
            bcnt_hold <= bcnt_hold_n;
        end
    end

    always_comb begin
        state_n     = state;
        cur_addr_n  = cur_addr;
        rem_n       = rem;
        sub_rem_n   = sub_rem;
        bcnt_hold_n = bcnt_hold;
        len_v       = '0;
        m_wreq      = 1'b0;
        m_rreq      = 1'b0;
        m_addr      = cur_addr;
        m_bcnt      = bcnt_hold;
        s_busy      = m_busy;
        case (state)
            IDLE: begin
                m_addr = s_addr;
                len_v  = sub_len(s_addr[MBWIDTH-1:0], n_s);
                m_bcnt = MBWIDTH'(len_v - RW'(1));
                if (s_wreq) begin
                    m_wreq = 1'b1;
                    if (!m_busy) begin
                        cur_addr_n  = s_addr + AWIDTH'(1);
                        rem_n       = n_s - RW'(1);
                        sub_rem_n   = len_v - RW'(1);
                        bcnt_hold_n = MBWIDTH'(len_v - RW'(1));
                        if (rem_n != '0) state_n = WRITE;
                    end
                end else if (s_rreq) begin
                    m_rreq = 1'b1;
                    if (!m_busy) begin
                        cur_addr_n = s_addr + AWIDTH'(len_v);
                        rem_n      = n_s - len_v;
                        if (rem_n != '0) state_n = READ;
                    end
                end
            end
            WRITE: begin
                m_wreq = s_wreq;
                // A new sub-burst starts when the previous one has been fully issued
                if (sub_rem == '0) begin
                    len_v  = sub_len(cur_addr[MBWIDTH-1:0], rem);
                    m_bcnt = MBWIDTH'(len_v - RW'(1));
                end
                if (s_wreq && !m_busy) begin
                    cur_addr_n = cur_addr + AWIDTH'(1);
                    rem_n      = rem - RW'(1);
                    if (sub_rem == '0) begin
                        sub_rem_n   = len_v - RW'(1);
                        bcnt_hold_n = MBWIDTH'(len_v - RW'(1));
                    end else begin
                        sub_rem_n = sub_rem - RW'(1);
                    end
                    if (rem_n == '0) state_n = IDLE;
                end
            end
            READ: begin
                s_busy = 1'b1;
                m_rreq = 1'b1;
                len_v  = sub_len(cur_addr[MBWIDTH-1:0], rem);
                m_bcnt = MBWIDTH'(len_v - RW'(1));
                if (!m_busy) begin
                    cur_addr_n = cur_addr + AWIDTH'(len_v);
                    rem_n      = rem - len_v;
                    if (rem_n == '0) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Requests are never forwarded while reset is held
        if (reset) begin
            m_wreq = 1'b0;
            m_rreq = 1'b0;
        end
    end

endmodule
